// File: rtl/cipher_pkg.sv
// Shared encodings for the cipher stream demux: engine selects, the default
// end-of-message token, FSM state codes and the engine rise timeout.
package cipher_pkg;

  localparam logic [1:0] SEL_CAESAR  = 2'd0;
  localparam logic [1:0] SEL_SCYTALE = 2'd1;
  localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
  localparam logic [1:0] SEL_INVALID = 2'd3;

  localparam logic [7:0] START_TOKEN_DEFAULT = 8'hFA;

  localparam logic [0:0] IN_IDLE = 1'b0;
  localparam logic [0:0] IN_MSG  = 1'b1;

  localparam logic [1:0] OUT_POP       = 2'd0;
  localparam logic [1:0] OUT_WAIT_RISE = 2'd1;
  localparam logic [1:0] OUT_WAIT_FALL = 2'd2;

  // Cycles an engine gets to raise busy after receiving a token.
  localparam int RISE_TIMEOUT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read so the consumer can
// decide on a pop in the same cycle the entry becomes visible.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cipher_stream_demux.sv
// Routes whole messages (token included) from the encrypted stream to the
// engine chosen at message start, stalling while that engine decrypts.
module cipher_stream_demux
  import cipher_pkg::*;
#(
  parameter int                 D_WIDTH                = 8,
  parameter int                 FIFO_DEPTH             = 8,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(START_TOKEN_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  input  logic [1:0]         select_i,
  input  logic [2:0]         busy_i,
  output logic               ready_o,
  output logic [D_WIDTH-1:0] data0_o,
  output logic [D_WIDTH-1:0] data1_o,
  output logic [D_WIDTH-1:0] data2_o,
  output logic               valid0_o,
  output logic               valid1_o,
  output logic               valid2_o,
  output logic               overflow_o
);

  localparam int         EW = 2 + D_WIDTH;
  localparam int         CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] CH_SEL [3] = '{SEL_CAESAR, SEL_SCYTALE, SEL_ZIGZAG};

  logic [0:0]         in_state_q, in_state_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         out_state_q, out_state_d;
  logic [1:0]         wait_sel_q, wait_sel_d;
  logic [2:0]         wait_cnt_q, wait_cnt_d;
  logic               overflow_q, overflow_d;

  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [EW-1:0]      fifo_rdata;
  logic               in_idle, push, pop, push_tok;
  logic [1:0]         push_sel, head_sel;
  logic [D_WIDTH-1:0] head_data;
  logic [3:0]         busy_ext;

  assign ready_o   = (fifo_count != CW'(FIFO_DEPTH));
  assign in_idle   = (in_state_q == IN_IDLE);
  assign push_sel  = in_idle ? select_i : sel_q;
  assign push_tok  = (data_i == START_DECRYPTION_TOKEN);
  assign push      = valid_i && !fifo_full && !(in_idle && select_i == SEL_INVALID);
  assign overflow_d = valid_i && !push;

  assign head_sel  = fifo_rdata[EW-1 -: 2];
  assign head_data = fifo_rdata[D_WIDTH-1:0];
  // The invalid select code never reaches the FIFO; treat it as permanently busy.
  assign busy_ext  = {1'b1, busy_i};
  assign pop       = (out_state_q == OUT_POP) && !fifo_empty && !busy_ext[head_sel];

  always_comb begin
    in_state_d = in_state_q;
    sel_d      = sel_q;
    if (push) begin
      if (in_idle) sel_d = select_i;
      in_state_d = push_tok ? IN_IDLE : IN_MSG;
    end
  end

  always_comb begin
    out_state_d = out_state_q;
    wait_sel_d  = wait_sel_q;
    wait_cnt_d  = wait_cnt_q;
    case (out_state_q)
      OUT_POP: begin
        if (pop && head_data == START_DECRYPTION_TOKEN) begin
          wait_sel_d  = head_sel;
          wait_cnt_d  = '0;
          out_state_d = OUT_WAIT_RISE;
        end
      end
      OUT_WAIT_RISE: begin
        if (busy_ext[wait_sel_q])                      out_state_d = OUT_WAIT_FALL;
        else if (wait_cnt_q == 3'(RISE_TIMEOUT - 1))   out_state_d = OUT_POP;
        else                                           wait_cnt_d  = wait_cnt_q + 1'b1;
      end
      OUT_WAIT_FALL: begin
        if (!busy_ext[wait_sel_q]) out_state_d = OUT_POP;
      end
      default: out_state_d = OUT_POP;
    endcase
  end

  sync_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .wdata_i({push_sel, data_i}),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q  <= IN_IDLE;
      sel_q       <= SEL_CAESAR;
      out_state_q <= OUT_POP;
      wait_sel_q  <= SEL_CAESAR;
      wait_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      sel_q       <= sel_d;
      out_state_q <= out_state_d;
      wait_sel_q  <= wait_sel_d;
      wait_cnt_q  <= wait_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic               hit;
    logic [D_WIDTH-1:0] data_q;
    logic               valid_q;

    assign hit = pop && (head_sel == CH_SEL[gi]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= hit;
        if (hit) data_q <= head_data;
      end
    end
  end

  assign data0_o    = g_lane[0].data_q;
  assign data1_o    = g_lane[1].data_q;
  assign data2_o    = g_lane[2].data_q;
  assign valid0_o   = g_lane[0].valid_q;
  assign valid1_o   = g_lane[1].valid_q;
  assign valid2_o   = g_lane[2].valid_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_cipher_stream_demux.sv
// Scoreboard bench: the driver predicts routing per message, the monitor pops
// expectations on every output strobe, and a small engine model drives busy.
module tb_cipher_stream_demux;
  import cipher_pkg::*;

  localparam int         DEPTH = 8;
  localparam logic [7:0] TOK   = START_TOKEN_DEFAULT;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic [1:0] select_i = 2'd0;
  logic [2:0] busy_i = 3'b000;
  logic       ready_o;
  logic [7:0] data0_o, data1_o, data2_o;
  logic       valid0_o, valid1_o, valid2_o;
  logic       overflow_o;

  cipher_stream_demux dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .select_i  (select_i),
    .busy_i    (busy_i),
    .ready_o   (ready_o),
    .data0_o   (data0_o),
    .data1_o   (data1_o),
    .data2_o   (data2_o),
    .valid0_o  (valid0_o),
    .valid1_o  (valid1_o),
    .valid2_o  (valid2_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  exp_t       exp_q [3][$];
  int         acc = 0;
  int         pops = 0;
  bit         in_msg = 1'b0;
  int         msg_sel = 0;
  bit         ovf_exp = 1'b0;
  bit         mon_en = 1'b0;
  bit         blocked = 1'b0;
  bit         rose = 1'b0;
  int         blk_n = 0;
  int         wk = 0;
  bit         tok_seen [3] = '{default: 1'b0};
  logic [7:0] last_d [3] = '{default: 8'h00};
  bit         auto_eng = 1'b0;
  logic [2:0] busy_force = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
  endfunction

  // Called at posedge+2: predicts what the next edge does with these inputs.
  task automatic send(input bit v, input logic [7:0] d, input logic [1:0] s, input int lat);
    bit   rdy;
    int   ch;
    exp_t e;
    rdy = ((acc - pops) != DEPTH);
    check("ready", 32'(ready_o), 32'(rdy));
    ovf_exp = 1'b0;
    if (v) begin
      if (!rdy || (!in_msg && s == SEL_INVALID)) begin
        ovf_exp = 1'b1;
      end else begin
        ch    = in_msg ? msg_sel : int'(s);
        e.d   = d;
        e.due = (lat >= 0) ? cyc + lat : -1;
        exp_q[ch].push_back(e);
        acc++;
        if (d == TOK) in_msg = 1'b0;
        else begin
          in_msg  = 1'b1;
          msg_sel = ch;
        end
      end
    end
    valid_i  = v;
    data_i   = d;
    select_i = s;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      send(1'b0, 8'h00, 2'd0, -1);
      n++;
    end
    check("drain", 32'(pending()), 32'd0);
  endtask

  task automatic monitor_step();
    logic [2:0] v;
    logic [7:0] d [3];
    exp_t       e;
    v    = {valid2_o, valid1_o, valid0_o};
    d[0] = data0_o;
    d[1] = data1_o;
    d[2] = data2_o;
    check("overflow", 32'(overflow_o), 32'(ovf_exp));
    check("onehot", 32'($countones(v) <= 1), 32'd1);
    // After a token the demux must sit out until the engine has been busy and
    // gone idle again, or until it stayed idle for four sampled edges.
    if (blocked) begin
      check("stall", 32'(v), 32'd0);
      blk_n++;
      if (!rose) begin
        if (busy_i[wk]) rose = 1'b1;
        else if (blk_n == RISE_TIMEOUT) blocked = 1'b0;
      end else if (!busy_i[wk]) begin
        blocked = 1'b0;
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (v[k]) begin
        pops++;
        check("busy_gate", 32'(busy_i[k]), 32'd0);
        if (exp_q[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious: ch%0d got %h expected nothing at cycle %0d", k, d[k], cyc);
        end else begin
          e = exp_q[k].pop_front();
          check($sformatf("data%0d", k), 32'(d[k]), 32'(e.d));
          if (e.due >= 0) check("latency", 32'(cyc), 32'(e.due));
        end
        $display("ch%0d data=%h cycle=%0d", k, d[k], cyc);
        last_d[k] = d[k];
        if (d[k] == TOK) begin
          blocked     = 1'b1;
          rose        = 1'b0;
          blk_n       = 0;
          wk          = k;
          tok_seen[k] = 1'b1;
        end
      end else begin
        check($sformatf("hold%0d", k), 32'(d[k]), 32'(last_d[k]));
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) monitor_step();
    end
  end

  // Engine model: after a token it usually raises busy within 0..2 cycles for
  // 2..8 cycles, sometimes ignores it; idle engines blip busy occasionally.
  initial begin
    int         dly [3];
    int         hold [3];
    bit         pend [3];
    logic [2:0] b;
    for (int k = 0; k < 3; k++) begin
      dly[k]  = 0;
      hold[k] = 0;
      pend[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #3;
      if (!auto_eng) begin
        busy_i = busy_force;
        for (int k = 0; k < 3; k++) begin
          tok_seen[k] = 1'b0;
          pend[k]     = 1'b0;
        end
      end else begin
        b = 3'b000;
        for (int k = 0; k < 3; k++) begin
          if (tok_seen[k]) begin
            tok_seen[k] = 1'b0;
            if ($urandom_range(0, 3) != 0) begin
              pend[k] = 1'b1;
              dly[k]  = int'($urandom_range(0, 2));
              hold[k] = int'($urandom_range(2, 8));
            end
          end
          if (pend[k]) begin
            if (dly[k] > 0) dly[k]--;
            else begin
              b[k] = 1'b1;
              hold[k]--;
              if (hold[k] == 0) pend[k] = 1'b0;
            end
          end else begin
            b[k] = ($urandom_range(0, 15) == 0);
          end
        end
        busy_i = b;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #10;
    check("rst_valid", 32'({valid2_o, valid1_o, valid0_o}), 32'd0);
    check("rst_data", 32'({data2_o, data1_o, data0_o}), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #2;
    mon_en = 1'b1;

    // Back-to-back message on scytale with idle engines: 2-cycle latency.
    send(1'b1, 8'h41, 2'd1, 2);
    send(1'b1, 8'h42, 2'd1, 2);
    send(1'b1, 8'h43, 2'd1, 2);
    send(1'b1, TOK,   2'd1, 2);
    wait_drain(20);

    // Scytale engine busy for 10 cycles while a Caesar message queues up.
    busy_force = 3'b010;
    send(1'b1, 8'h55, 2'd0, -1);
    send(1'b1, TOK,   2'd0, -1);
    repeat (8) send(1'b0, 8'h00, 2'd0, -1);
    check("busy_held", 32'(exp_q[0].size()), 32'd2);
    busy_force = 3'b000;
    wait_drain(30);

    // select_i changes mid-message and must be ignored.
    send(1'b1, 8'h10, 2'd1, -1);
    send(1'b1, 8'h11, 2'd2, -1);
    send(1'b1, TOK,   2'd2, -1);
    wait_drain(30);

    // Fill the FIFO while stalled; the ninth character is dropped.
    busy_force = 3'b111;
    for (int i = 0; i < 9; i++) send(1'b1, 8'h60 + 8'(i), 2'd0, -1);
    check("full_ready", 32'(ready_o), 32'd0);
    busy_force = 3'b000;
    wait_drain(40);
    send(1'b1, TOK, 2'd0, -1);
    wait_drain(30);

    // Invalid select at message start.
    send(1'b1, 8'h20, SEL_INVALID, -1);
    repeat (3) send(1'b0, 8'h00, 2'd0, -1);
    check("inv_ready", 32'(ready_o), 32'd1);

    // Asynchronous reset mid-message with five characters buffered.
    busy_force = 3'b111;
    for (int i = 0; i < 5; i++) send(1'b1, 8'h70 + 8'(i), 2'd2, -1);
    #4;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("arst_valid", 32'({valid2_o, valid1_o, valid0_o}), 32'd0);
    check("arst_data", 32'({data2_o, data1_o, data0_o}), 32'd0);
    check("arst_ovf", 32'(overflow_o), 32'd0);
    check("arst_ready", 32'(ready_o), 32'd1);
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      last_d[k]   = 8'h00;
      tok_seen[k] = 1'b0;
    end
    acc        = 0;
    pops       = 0;
    in_msg     = 1'b0;
    blocked    = 1'b0;
    ovf_exp    = 1'b0;
    valid_i    = 1'b0;
    busy_force = 3'b000;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #2;
    mon_en = 1'b1;
    send(1'b1, 8'h33, 2'd0, 2);
    send(1'b1, TOK,   2'd0, 2);
    wait_drain(30);

    // Randomized traffic against reactive engines.
    auto_eng = 1'b1;
    repeat (2500) begin
      logic       v;
      logic [1:0] s;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) == 0) ? SEL_INVALID : 2'($urandom_range(0, 2));
      d = ($urandom_range(0, 5) == 0) ? TOK : 8'($urandom_range(0, 255));
      send(v, d, s, -1);
    end
    wait_drain(800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
